// File: rtl/l2norm_batch_engine_if.sv
// Load/result handshake bundle for l2norm_batch_engine. The master side drives
// elements and consumes results; the slave side is the engine.
interface l2norm_batch_engine_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ACC_W = 2 * WIDTH + $clog2(DEPTH);

    logic [CNT_W-1:0] batch_size;
    logic             input_valid;
    logic             input_ready;
    logic [WIDTH-1:0] ax;
    logic             output_valid;
    logic             output_ready;
    logic [ACC_W-1:0] res;

    modport master (
        output batch_size, input_valid, ax, output_ready,
        input  input_ready, output_valid, res
    );

    modport slave (
        input  batch_size, input_valid, ax, output_ready,
        output input_ready, output_valid, res
    );
endinterface

// File: rtl/l2norm_batch_engine.sv
// Buffers DEPTH unsigned elements, then emits one L2 norm (or raw sum of squares)
// per batch. Define L2NORM_SQRT_EN to include the bit-serial integer square root.
module l2norm_batch_engine #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int LANES = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int ACC_W = 2 * WIDTH + $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    l2norm_batch_engine_if.slave bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     load_count,
    output logic                 cfg_err
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int LANE_SH = $clog2(LANES);
    localparam int SQ_W    = 2 * WIDTH;

    typedef enum logic [2:0] {
        IDLE, LOAD, SQUARE, ACCUM, CHECK, SQRT, RESULT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [SQ_W-1:0]  sq_p0 [LANES];
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] lane_sum;
    logic [ACC_W-1:0] res_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] batch_idx;
    logic [CNT_W-1:0] batch_last;
    logic [CNT_W-1:0] micro;
    logic [CNT_W-1:0] micro_last;
    logic [ADDR_W-1:0] rd_ptr;
    logic             in_ready;
    logic             in_fire;

    // A legal batch is a power of two between LANES and DEPTH inclusive.
    function automatic logic legal_batch(input logic [CNT_W-1:0] b);
        return (b != '0) &&
               ((b & CNT_W'(LANES - 1)) == '0) &&
               ((b & (b - CNT_W'(1))) == '0) &&
               (b <= CNT_W'(DEPTH));
    endfunction

    function automatic logic [CNT_W-1:0] log2_pow2(input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] lg;
        lg = '0;
        for (int i = 0; i < CNT_W; i++)
            if (b[i]) lg = CNT_W'(i);
        return lg;
    endfunction

    function automatic logic [SQ_W-1:0] square_u(input logic [WIDTH-1:0] x);
        return SQ_W'(x) * SQ_W'(x);
    endfunction

    assign in_ready         = ((state == IDLE) || (state == LOAD)) && (load_count < CNT_W'(DEPTH));
    assign in_fire          = bus.input_valid && in_ready;
    assign bus.input_ready  = in_ready;
    assign bus.output_valid = out_valid_r;
    assign bus.res          = res_r;
    assign busy             = (state != IDLE);

    always_ff @(posedge clock) begin
        if (in_fire)
            mem[load_count[ADDR_W-1:0]] <= bus.ax;
    end

    // Stage p0: one LANES-wide slice of the current batch squared at full width.
    always_ff @(posedge clock) begin
        if (state == SQUARE)
            for (int i = 0; i < LANES; i++)
                sq_p0[i] <= square_u(mem[rd_ptr + ADDR_W'(i)]);
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++)
            lane_sum = lane_sum + ACC_W'(sq_p0[i]);
    end

`ifdef L2NORM_SQRT_EN
    localparam int SQRT_S = (ACC_W + 1) / 2;
    localparam int RAD_W  = 2 * SQRT_S;
    localparam int REM_W  = SQRT_S + 3;
    localparam int SC_W   = $clog2(SQRT_S + 1);

    logic [RAD_W-1:0]        rad_p1;
    logic [REM_W-1:0]        rem_p1;
    logic [SQRT_S-1:0]       root_p1;
    logic [SC_W-1:0]         sqrt_cnt;
    logic [REM_W+SQRT_S-1:0] sqrt_next;

    // One restoring step: bring down the next radicand bit pair and try root*4+1.
    function automatic logic [REM_W+SQRT_S-1:0] sqrt_step(
        input logic [REM_W-1:0]  rem,
        input logic [SQRT_S-1:0] root,
        input logic [1:0]        pair
    );
        logic [REM_W-1:0] cand;
        logic [REM_W-1:0] trial;
        cand  = {rem[REM_W-3:0], pair};
        trial = REM_W'({root, 2'b01});
        if (cand >= trial)
            return {cand - trial, root[SQRT_S-2:0], 1'b1};
        return {cand, root[SQRT_S-2:0], 1'b0};
    endfunction

    assign sqrt_next = sqrt_step(rem_p1, root_p1, rad_p1[RAD_W-1 -: 2]);

    // Stage p1: radicand captured during CHECK, then one root bit per SQRT cycle.
    always_ff @(posedge clock) begin
        if (state == CHECK) begin
            rad_p1   <= RAD_W'(acc);
            rem_p1   <= '0;
            root_p1  <= '0;
            sqrt_cnt <= '0;
        end else if (state == SQRT) begin
            rad_p1            <= rad_p1 << 2;
            {rem_p1, root_p1} <= sqrt_next;
            sqrt_cnt          <= sqrt_cnt + SC_W'(1);
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            load_count  <= '0;
            batch_idx   <= '0;
            batch_last  <= '0;
            micro       <= '0;
            micro_last  <= '0;
            rd_ptr      <= '0;
            acc         <= '0;
            res_r       <= '0;
            out_valid_r <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        load_count <= CNT_W'(1);
                        state      <= LOAD;
                        if (legal_batch(bus.batch_size)) begin
                            micro_last <= (bus.batch_size >> LANE_SH) - CNT_W'(1);
                            batch_last <= (CNT_W'(DEPTH) >> log2_pow2(bus.batch_size)) - CNT_W'(1);
                        end else begin
                            cfg_err    <= 1'b1;
                            micro_last <= CNT_W'(DEPTH / LANES - 1);
                            batch_last <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (in_fire)
                        load_count <= load_count + CNT_W'(1);
                    if ((in_fire && load_count == CNT_W'(DEPTH - 1)) ||
                        (load_count == CNT_W'(DEPTH))) begin
                        state     <= SQUARE;
                        batch_idx <= '0;
                        micro     <= '0;
                        rd_ptr    <= '0;
                        acc       <= '0;
                    end
                end
                SQUARE: begin
                    rd_ptr <= rd_ptr + ADDR_W'(LANES);
                    state  <= ACCUM;
                end
                ACCUM: begin
                    acc   <= acc + lane_sum;
                    state <= CHECK;
                end
                CHECK: begin
                    if (micro == micro_last) begin
`ifdef L2NORM_SQRT_EN
                        state <= SQRT;
`else
                        state       <= RESULT;
                        res_r       <= acc;
                        out_valid_r <= 1'b1;
`endif
                    end else begin
                        micro <= micro + CNT_W'(1);
                        state <= SQUARE;
                    end
                end
`ifdef L2NORM_SQRT_EN
                SQRT: begin
                    if (sqrt_cnt == SC_W'(SQRT_S - 1)) begin
                        state       <= RESULT;
                        res_r       <= ACC_W'(sqrt_next[SQRT_S-1:0]);
                        out_valid_r <= 1'b1;
                    end
                end
`endif
                RESULT: begin
                    if (bus.output_ready) begin
                        out_valid_r <= 1'b0;
                        if (batch_idx == batch_last) begin
                            state      <= IDLE;
                            load_count <= '0;
                            batch_idx  <= '0;
                        end else begin
                            batch_idx <= batch_idx + CNT_W'(1);
                            micro     <= '0;
                            acc       <= '0;
                            state     <= SQUARE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/l2norm_batch_engine.md
L2NORM_BATCH_ENGINE -- requirements
Module: l2norm_batch_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the element width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, the buffer depth in elements (power of two, >= LANES).
REQ-003 SHALL have parameter LANES, default 32, the number of parallel squarers (power of two).
REQ-004 SHALL use derived widths CNT_W = $clog2(DEPTH)+1 and ACC_W = 2*WIDTH + $clog2(DEPTH).
REQ-005 SHALL have one clock and a synchronous, active-high reset; the ports are named clock and reset.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 batch_size  input  CNT_W  elements per batch; sampled on the first load handshake.
REQ-009 input_valid / input_ready  in / out  1  load handshake.
REQ-010 ax  input  WIDTH  unsigned element data.
REQ-011 output_valid / output_ready  out / in  1  result handshake.
REQ-012 res  output  ACC_W  per-batch result.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 load_count  output  CNT_W  number of elements accepted.
REQ-015 cfg_err  output  1  sticky flag for an illegal batch_size.

Function
REQ-016 SHALL implement the states IDLE, LOAD, SQUARE, ACCUM, CHECK, SQRT and RESULT.
REQ-017 input_ready = (IDLE or LOAD) and load_count < DEPTH; a transfer occurs only when input_valid and input_ready are both high.
REQ-018 IDLE + handshake: write ax to mem[0], set load_count = 1, latch batch_size, go to LOAD.
REQ-019 LOAD: each handshake writes mem[load_count] and increments load_count; when load_count == DEPTH, go to SQUARE with batch_idx = 0, acc = 0, micro = 0.
REQ-020 Illegal batch_size (zero, not a multiple of LANES, or not dividing DEPTH): set cfg_err = 1 and use DEPTH as the batch size.
REQ-021 SQUARE: register sq[i] = mem[batch_idx*B + micro*LANES + i]^2 for i < LANES, full 2*WIDTH-bit product, no truncation.
REQ-022 ACCUM: acc += sum of sq[0..LANES-1], with an ACC_W-bit accumulator that never overflows.
REQ-023 CHECK: if micro == B/LANES - 1, go to SQRT; otherwise micro++ and return to SQUARE.
REQ-024 SQRT: restoring bit-serial integer sqrt producing one root bit per cycle for ceil(ACC_W/2) cycles; result = floor(sqrt(acc)), zero-extended to ACC_W.
REQ-025 RESULT: output_valid = 1 and res is held stable until output_ready is high.
REQ-026 RESULT handshake, not last batch: batch_idx++, acc = 0, micro = 0, go to SQUARE.
REQ-027 RESULT handshake on the last batch (batch_idx == DEPTH/B - 1): go to IDLE, load_count = 0; exactly DEPTH/B results are emitted per load.
REQ-028 Latency: output_valid rises exactly 3*(B/LANES) + S cycles after SQUARE entry, where S = ceil(ACC_W/2) with the sqrt compiled in, else 0.
REQ-029 input_valid outside IDLE/LOAD or while load_count == DEPTH SHALL be ignored, with no memory write.
REQ-030 output_ready outside RESULT SHALL have no effect.

Reset
REQ-031 reset SHALL force state = IDLE, load_count = 0, batch_idx = 0, micro = 0, acc = 0, res = 0 and cfg_err = 0 on the next edge, from any state including mid-SQRT.
REQ-032 After reset: output_valid = 0, busy = 0, and input_ready = 1.
REQ-033 Buffer contents after reset are don't-care.

Configuration
REQ-034 L2NORM_SQRT_EN defined: the SQRT state exists and res is the integer root per REQ-024.
REQ-035 L2NORM_SQRT_EN undefined: CHECK goes directly to RESULT, res = acc (raw sum of squares), S = 0, and the sqrt datapath is absent.

Verification (WIDTH=8, DEPTH=16, LANES=4, ACC_W=20)
REQ-036 Sqrt on; batch_size=4; all ax=3 -> 4 results, each res=6.
REQ-037 batch_size=16; ax=0..15 -> one result: res=35 with sqrt, 1240 without; output_valid 22 cycles (sqrt) / 12 cycles (no sqrt) after SQUARE entry.
REQ-038 batch_size=16; all ax=255 -> res=1020 with sqrt, 1040400 without.
REQ-039 batch_size=6 -> cfg_err=1, single result computed over 16 elements.
REQ-040 output_ready held low 5 cycles in RESULT -> output_valid stays 1 and res stays unchanged.
REQ-041 reset pulsed mid-SQRT -> next cycle busy=0, output_valid=0, load_count=0, input_ready=1.
